// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer (rst_seq).
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_SWHOLD = 3'd4
  } state_e;

  // Counter value in RUN at which channel k is released (takes effect one cycle later).
  function automatic logic [63:0] rel_point(input int unsigned    k,
                                            input longint unsigned base,
                                            input longint unsigned stage);
    return base + 64'(k) * stage;
  endfunction

endpackage

// File: rtl/rst_seq_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq.sv
// Multi-channel reset sequencer: filters PLL lock, then releases resets in staged order.
// Optional lock-loss counter output enabled by defining RST_SEQ_LOSS_CNT_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned     N_CH      = 3,
  parameter int unsigned     CNT_W     = 34,
  parameter int unsigned     LOCK_FILT = 1000,
  parameter longint unsigned BASE_DLY  = 64'd5_000_000_000,
  parameter longint unsigned STAGE_DLY = 64'd100_000,
  parameter int unsigned     SW_HOLD   = 1000
) (
  input  logic            clk_100M,
  input  logic            rst_n,
  input  logic            locked,
  input  logic            sw_rst_req,
  output logic [N_CH-1:0] chan_rst_n,
  output logic            done,
`ifdef RST_SEQ_LOSS_CNT_EN
  output logic [7:0]      loss_cnt,
`endif
  output logic [2:0]      state_o
);

  localparam logic [CNT_W-1:0] FILT_END = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(SW_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             locked_s;
  logic             lock_lost;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_CH-1:0]  chan_q;
  logic [N_CH-1:0]  hit;
  logic             done_q;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk_i  (clk_100M),
    .rst_ni (rst_n),
    .d_i    (locked),
    .q_o    (locked_s)
  );

  for (genvar k = 0; k < N_CH; k++) begin : g_rel
    localparam logic [CNT_W-1:0] REL = CNT_W'(rel_point(k, BASE_DLY, STAGE_DLY));
    assign hit[k] = (cnt_q == REL);
  end

  assign lock_lost = (state_q != ST_IDLE) && !locked_s;

  // Lock loss overrides everything, including a simultaneous software request.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
    end else if (lock_lost) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (locked_s) begin
            state_q <= ST_FILT;
            cnt_q   <= '0;
          end
        end
        ST_FILT: begin
          if (cnt_q == FILT_END) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (sw_rst_req) begin
            state_q <= ST_SWHOLD;
            cnt_q   <= '0;
            chan_q  <= '0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            chan_q <= chan_q | hit;
            if (hit[N_CH-1]) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (sw_rst_req) begin
            state_q <= ST_SWHOLD;
            cnt_q   <= '0;
            chan_q  <= '0;
            done_q  <= 1'b0;
          end
        end
        ST_SWHOLD: begin
          if (sw_rst_req) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_END) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          chan_q  <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (lock_lost && (loss_q != '1)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`endif

  assign chan_rst_n = chan_q;
  assign done       = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed scenarios plus random lock/sw stimulus against a phase/elapsed-time model.
module tb_rst_seq;

  localparam int NCH = 3;
  localparam int LF  = 4;
  localparam int BD  = 10;
  localparam int SD  = 5;
  localparam int SH  = 8;

  logic           clk_100M = 1'b0;
  logic           rst_n = 1'b0;
  logic           locked = 1'b0;
  logic           sw_rst_req = 1'b0;
  logic [NCH-1:0] chan_rst_n;
  logic           done;
  logic [2:0]     state_o;
`ifdef RST_SEQ_LOSS_CNT_EN
  logic [7:0]     loss_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: sync pipeline, phase (0 idle,1 filter,2 run,3 done,4 hold), elapsed cycles in phase.
  bit m_s1, m_s2;
  int m_ph, m_e, m_loss;

  always #5 clk_100M = ~clk_100M;

  rst_seq #(
    .N_CH      (NCH),
    .CNT_W     (8),
    .LOCK_FILT (LF),
    .BASE_DLY  (64'(BD)),
    .STAGE_DLY (64'(SD)),
    .SW_HOLD   (SH)
  ) dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .locked     (locked),
    .sw_rst_req (sw_rst_req),
    .chan_rst_n (chan_rst_n),
    .done       (done),
`ifdef RST_SEQ_LOSS_CNT_EN
    .loss_cnt   (loss_cnt),
`endif
    .state_o    (state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rel(input int k);
    return BD + k * SD;
  endfunction

  function automatic logic [NCH-1:0] exp_chan();
    logic [NCH-1:0] v = '0;
    if (m_ph == 3) v = '1;
    else if (m_ph == 2)
      for (int k = 0; k < NCH; k++)
        if (m_e >= rel(k) + 1) v[k] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_ph = 0; m_e = 0; m_loss = 0;
  endtask

  task automatic model_step(input bit l, input bit s);
    bit ls;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = l;
    if (m_ph != 0 && !ls) begin
      m_ph = 0; m_e = 0;
      if (m_loss < 255) m_loss++;
    end else begin
      case (m_ph)
        0: if (ls) begin m_ph = 1; m_e = 0; end
        1: begin m_e++; if (m_e == LF) begin m_ph = 2; m_e = 0; end end
        2: if (s) begin m_ph = 4; m_e = 0; end
           else begin m_e++; if (m_e >= rel(NCH-1) + 1) m_ph = 3; end
        3: if (s) begin m_ph = 4; m_e = 0; end
        4: if (s) m_e = 0;
           else begin m_e++; if (m_e == SH) begin m_ph = 2; m_e = 0; end end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("chan",  32'(chan_rst_n), 32'(exp_chan()));
    check("done",  32'(done),       (m_ph == 3) ? 32'd1 : 32'd0);
    check("state", 32'(state_o),    32'(m_ph));
`ifdef RST_SEQ_LOSS_CNT_EN
    check("loss",  32'(loss_cnt),   32'(m_loss));
`endif
  endtask

  task automatic tick(input bit l, input bit s);
    locked     = l;
    sw_rst_req = s;
    @(posedge clk_100M);
    model_step(l, s);
    #1;
    check_outputs();
  endtask

  initial begin
    // 1: reset held with lock present
    model_reset();
    rst_n  = 1'b0;
    locked = 1'b1;
    repeat (6) begin
      @(posedge clk_100M);
      #1;
      check("rst_chan",  32'(chan_rst_n), 32'd0);
      check("rst_done",  32'(done),       32'd0);
      check("rst_state", 32'(state_o),    32'd0);
    end
    locked = 1'b0;
    rst_n  = 1'b1;
    tick(0, 0);
    tick(0, 0);

    // 2: staged release; cycle 0 is the first edge sampling locked high
    for (int c = 0; c <= 30; c++) begin
      tick(1, 0);
      if (c == 16) check("t2_c16", 32'(chan_rst_n), 32'b000);
      if (c == 17) check("t2_c17", 32'(chan_rst_n), 32'b001);
      if (c == 21) check("t2_c21", 32'(chan_rst_n), 32'b001);
      if (c == 22) check("t2_c22", 32'(chan_rst_n), 32'b011);
      if (c == 26) check("t2_c26", 32'(done),       32'd0);
      if (c == 27) begin
        check("t2_c27", 32'(chan_rst_n), 32'b111);
        check("t2_done", 32'(done), 32'd1);
        check("t2_state", 32'(state_o), 32'd3);
      end
    end

    // 4: software re-sequence from DONE
    tick(1, 1);
    check("t4_hold", 32'(chan_rst_n), 32'd0);
    for (int c = 1; c <= 19; c++) begin
      tick(1, 0);
      if (c == 7)  check("t4_st7",  32'(state_o), 32'd4);
      if (c == 8)  check("t4_run",  32'(state_o), 32'd2);
      if (c == 18) check("t4_c18",  32'(chan_rst_n), 32'b000);
      if (c == 19) check("t4_c19",  32'(chan_rst_n), 32'b001);
    end

    // 5: lock loss in RUN with bit0 released
    tick(0, 0);
    tick(0, 0);
    check("t5_l1", 32'(chan_rst_n), 32'b001);
    tick(0, 0);
    check("t5_chan",  32'(chan_rst_n), 32'd0);
    check("t5_state", 32'(state_o),    32'd0);
    check("t5_done",  32'(done),       32'd0);
`ifdef RST_SEQ_LOSS_CNT_EN
    check("t5_loss",  32'(loss_cnt),   32'd1);
`endif

    // 3: short lock pulse aborts filtering
    repeat (3) tick(1, 0);
    repeat (8) tick(0, 0);
    check("t3_chan",  32'(chan_rst_n), 32'd0);
    check("t3_state", 32'(state_o),    32'd0);

    // 6: lock loss and sw request seen in the same cycle
    repeat (35) tick(1, 0);
    check("t6_pre", 32'(state_o), 32'd3);
    tick(0, 0);
    tick(0, 0);
    tick(0, 1);
    check("t6_state", 32'(state_o), 32'd0);

    // Random lock drops and sw pulses
    for (int c = 0; c < 3000; c++)
      tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 39) == 0));

    // Many lock losses for saturation
    for (int i = 0; i < 300; i++) begin
      repeat (4) tick(1, 0);
      repeat (4) tick(0, 0);
    end
`ifdef RST_SEQ_LOSS_CNT_EN
    check("loss_sat", 32'(loss_cnt), 32'd255);
`endif

    // Asynchronous reset mid-sequence
    repeat (20) tick(1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_chan",  32'(chan_rst_n), 32'd0);
    check("arst_state", 32'(state_o),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
